// File: rtl/neuro_soc.sv
// neuro_soc: 8-bit-PC CPU, 32-bit ALU and pixel-averaging classifier.
// Define NEURO_SOC_ALU_EXT_EN to enable ALU ops 2-7 (logic, shifts, pass).
module neuro_alu (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [3:0]  op_i,
   output logic [31:0] res_o,
   output logic        zero_o,
   output logic        gt_o
);
   always_comb begin
      res_o = '0;
      case (op_i)
         4'd0: res_o = a_i + b_i;
         4'd1: res_o = a_i - b_i;
`ifdef NEURO_SOC_ALU_EXT_EN
         4'd2: res_o = a_i & b_i;
         4'd3: res_o = a_i | b_i;
         4'd4: res_o = a_i ^ b_i;
         4'd5: res_o = a_i << b_i[4:0];
         4'd6: res_o = a_i >> b_i[4:0];
         4'd7: res_o = b_i;
`endif
         default: res_o = '0;
      endcase
   end

   assign zero_o = (res_o == '0);
   assign gt_o   = (a_i > b_i);
endmodule

module neuro_soc #(
   parameter int          NUM_PIXELS = 16,
   parameter logic [31:0] PROG0      = 32'h0709_0000,
   parameter logic [31:0] PROG1      = 32'h0600_0000,
   parameter logic [31:0] PROG2      = 32'h0000_0000,
   parameter logic [31:0] PROG3      = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pixel_in,
   input  logic       pixel_valid,
   output logic [1:0] class_out,
   output logic       done
);
   localparam int LW = $clog2(NUM_PIXELS);
   localparam int SW = 8 + LW;
   localparam logic [LW-1:0] LAST = LW'(NUM_PIXELS - 1);

   localparam logic [7:0] OP_ADD  = 8'h01;
   localparam logic [7:0] OP_ADDI = 8'h02;
   localparam logic [7:0] OP_BEQ  = 8'h03;
   localparam logic [7:0] OP_BGT  = 8'h04;
   localparam logic [7:0] OP_J    = 8'h05;
   localparam logic [7:0] OP_HALT = 8'h06;
   localparam logic [7:0] OP_NEUR = 8'h07;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;

   typedef enum logic [1:0] {
      C_IDLE,
      C_ACCUM,
      C_DONE
   } cls_e;

   logic [7:0]  pc_q, pc_d;
   logic        running_q, running_d;
   logic        start_q, start_d;
   logic [31:0] regs_q [16];

   cls_e          cls_q;
   logic          ready_q;
   logic          done_q;
   logic [SW-1:0] sum_q;
   logic [LW-1:0] cnt_q;
   logic [1:0]    class_q;
   logic [SW-1:0] sum_nxt;

   logic [31:0] imem [256];
   logic [31:0] instr;
   logic [7:0]  opc;
   logic [3:0]  rd_a, rs_a;
   logic [7:0]  imm;
   logic [31:0] imm_sx;
   logic [31:0] rd_val, rs_val, rt_val;

   logic [31:0] alu_a, alu_b, alu_res;
   logic [3:0]  alu_op;
   logic        alu_zero, alu_gt;

   logic        rf_we;
   logic [31:0] rf_wd;

   logic [31:0] dmem_q [256];
   logic        dmem_we;
   logic [31:0] dmem_rdata;
   logic        unused_bits;

   // Instruction ROM: program words at 0..3, NOP everywhere else.
   always_comb begin
      for (int i = 0; i < 256; i++) imem[i] = '0;
      imem[0] = PROG0;
      imem[1] = PROG1;
      imem[2] = PROG2;
      imem[3] = PROG3;
   end

   assign instr  = imem[pc_q];
   assign opc    = instr[31:24];
   assign rd_a   = instr[19:16];
   assign rs_a   = instr[11:8];
   assign imm    = instr[7:0];
   assign imm_sx = {{24{imm[7]}}, imm};
   assign rd_val = regs_q[rd_a];
   assign rs_val = regs_q[rs_a];
   assign rt_val = regs_q[imm[3:0]];

   // Data memory is reserved: addressed by r15, never written.
   assign dmem_we    = 1'b0;
   assign dmem_rdata = dmem_q[regs_q[15][7:0]];

   always_ff @(posedge clk) begin
      if (dmem_we) dmem_q[regs_q[15][7:0]] <= rd_val;
   end

   assign unused_bits = ^{dmem_rdata, instr[23:20], instr[15:12]};

   neuro_alu u_alu (
      .a_i    (alu_a),
      .b_i    (alu_b),
      .op_i   (alu_op),
      .res_o  (alu_res),
      .zero_o (alu_zero),
      .gt_o   (alu_gt)
   );

   always_comb begin
      pc_d      = pc_q;
      running_d = running_q;
      start_d   = start_q;
      rf_we     = 1'b0;
      rf_wd     = alu_res;
      alu_a     = rs_val;
      alu_b     = rt_val;
      alu_op    = ALU_ADD;
      if (running_q) begin
         case (opc)
            OP_ADD: begin
               rf_we = 1'b1;
               pc_d  = pc_q + 8'd1;
            end
            OP_ADDI: begin
               alu_b = imm_sx;
               rf_we = 1'b1;
               pc_d  = pc_q + 8'd1;
            end
            OP_BEQ: begin
               alu_a  = rd_val;
               alu_b  = rs_val;
               alu_op = ALU_SUB;
               pc_d   = alu_zero ? pc_q + imm : pc_q + 8'd1;
            end
            OP_BGT: begin
               alu_a  = rd_val;
               alu_b  = rs_val;
               alu_op = ALU_SUB;
               pc_d   = alu_gt ? pc_q + imm : pc_q + 8'd1;
            end
            OP_J:    pc_d = imm;
            OP_HALT: running_d = 1'b0;
            OP_NEUR: begin
               // Stall on this word until the classifier reports done.
               if (done_q) begin
                  rf_we   = 1'b1;
                  rf_wd   = {30'b0, class_q};
                  start_d = 1'b0;
                  pc_d    = pc_q + 8'd1;
               end else if (ready_q) begin
                  start_d = 1'b1;
               end
            end
            default: pc_d = pc_q + 8'd1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= '0;
         running_q <= 1'b1;
         start_q   <= 1'b0;
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      end else begin
         pc_q      <= pc_d;
         running_q <= running_d;
         start_q   <= start_d;
         if (rf_we) regs_q[rd_a] <= rf_wd;
      end
   end

   assign sum_nxt = sum_q + SW'(pixel_in);

   always_ff @(posedge clk) begin
      if (rst) begin
         cls_q   <= C_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cnt_q   <= '0;
         class_q <= '0;
      end else begin
         case (cls_q)
            C_IDLE: begin
               if (start_q) begin
                  sum_q   <= '0;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  cls_q   <= C_ACCUM;
               end
            end
            C_ACCUM: begin
               if (pixel_valid) begin
                  sum_q <= sum_nxt;
                  cnt_q <= cnt_q + LW'(1);
                  // Top two bits of the mean are the top two of the sum.
                  if (cnt_q == LAST) begin
                     class_q <= sum_nxt[SW-1:SW-2];
                     done_q  <= 1'b1;
                     cls_q   <= C_DONE;
                  end
               end
            end
            C_DONE: begin
               if (!start_q) begin
                  done_q  <= 1'b0;
                  ready_q <= 1'b1;
                  cls_q   <= C_IDLE;
               end
            end
            default: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               cls_q   <= C_IDLE;
            end
         endcase
      end
   end

   assign class_out = class_q;
   assign done      = done_q;
endmodule

// File: tb/tb_neuro_soc.sv
// Testbench for neuro_soc: ALU vectors, classification runs, reset, program.
module tb_neuro_soc;
   localparam int N = 16;
   localparam int LIMIT = 400;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pixel_in;
   logic       pixel_valid;
   logic [1:0] class_out;
   logic       done;
   logic [1:0] class_b;
   logic       done_b;

   logic [31:0] alu_a, alu_b, alu_res;
   logic [3:0]  alu_op;
   logic        alu_z, alu_g;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   neuro_soc #(.NUM_PIXELS(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .pixel_in    (pixel_in),
      .pixel_valid (pixel_valid),
      .class_out   (class_out),
      .done        (done)
   );

   neuro_soc #(
      .NUM_PIXELS (N),
      .PROG0      (32'h0201_0003),
      .PROG1      (32'h0202_0201),
      .PROG2      (32'h0401_02FF),
      .PROG3      (32'h0600_0000)
   ) pdut (
      .clk         (clk),
      .rst         (rst),
      .pixel_in    (8'd0),
      .pixel_valid (1'b0),
      .class_out   (class_b),
      .done        (done_b)
   );

   neuro_alu u_alu (
      .a_i    (alu_a),
      .b_i    (alu_b),
      .op_i   (alu_op),
      .res_o  (alu_res),
      .zero_o (alu_z),
      .gt_o   (alu_g)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] res;
      logic        z;
      logic        g;
   } alu_vec_t;

   typedef struct {
      int         mode;
      logic [7:0] val;
      int         cls;
   } run_vec_t;

   // mode 0: constant pixel, always valid; 1: valid every other cycle,
   // values alternating 255/0; 2: random. cls < 0 means use the model.
   task automatic run_class(input int mode, input logic [7:0] val,
                            input int cls, input string tag);
      int sum = 0;
      int cnt = 0;
      int exp_edge = 0;
      int dut_edge = 0;
      int exp_cls = 0;
      bit tog = 1'b1;
      rst = 1'b1;
      pixel_valid = 1'b0;
      pixel_in = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk({tag, "_rst_done"}, 32'(done), 32'd0);
      chk({tag, "_rst_class"}, 32'(class_out), 32'd0);
      chk({tag, "_rst_pc"}, 32'(dut.pc_q), 32'd0);
      for (int e = 1; e <= LIMIT; e++) begin
         case (mode)
            0: begin
               pixel_valid = 1'b1;
               pixel_in = val;
            end
            1: begin
               pixel_valid = (e % 2) == 1;
               if (pixel_valid) begin
                  pixel_in = tog ? 8'd255 : 8'd0;
                  tog = ~tog;
               end
            end
            default: begin
               pixel_valid = 1'($urandom_range(0, 1));
               pixel_in = 8'($urandom_range(0, 255));
            end
         endcase
         @(posedge clk);
         #1;
         // Classifier accepts pixels from the third edge after release.
         if (e >= 3 && cnt < N && pixel_valid) begin
            sum += int'(pixel_in);
            cnt++;
            if (cnt == N) begin
               exp_edge = e;
               exp_cls = (sum / N) / 64;
            end
         end
         if (done && dut_edge == 0) dut_edge = e;
         if (exp_edge != 0 && e >= exp_edge + 3) break;
      end
      if (cls >= 0) exp_cls = cls;
      if (exp_edge == 0) begin
         errors++;
         checks++;
         $display("FAIL %s_timeout: actual=no_done required=done", tag);
      end else begin
         chk({tag, "_done_edge"}, 32'(dut_edge), 32'(exp_edge));
         chk({tag, "_class"}, 32'(class_out), 32'(exp_cls));
         chk({tag, "_r9"}, dut.regs_q[9], 32'(exp_cls));
         chk({tag, "_pc"}, 32'(dut.pc_q), 32'd1);
         chk({tag, "_running"}, 32'(dut.running_q), 32'd0);
         chk({tag, "_done_low"}, 32'(done), 32'd0);
      end
   endtask

   alu_vec_t av[9];
   run_vec_t rv[4];
   logic [31:0] ea, eb;

   initial begin
      av[0] = '{32'd3, 32'd4, 4'd0, 32'd7, 1'b0, 1'b0};
      av[1] = '{32'd5, 32'd7, 4'd1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      av[2] = '{32'd9, 32'd9, 4'd1, 32'd0, 1'b1, 1'b0};
      av[3] = '{32'd9, 32'd5, 4'd1, 32'd4, 1'b0, 1'b1};
      av[4] = '{32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b1, 1'b1};
      av[8] = '{32'd6, 32'd2, 4'd15, 32'd0, 1'b1, 1'b1};
`ifdef NEURO_SOC_ALU_EXT_EN
      av[5] = '{32'h0000_F0F0, 32'h0000_0FF0, 4'd4, 32'h0000_FF00, 1'b0, 1'b1};
      av[6] = '{32'd1, 32'd31, 4'd5, 32'h8000_0000, 1'b0, 1'b0};
      av[7] = '{32'h0000_F0F0, 32'h0000_0FF0, 4'd2, 32'h0000_00F0, 1'b0, 1'b1};
`else
      av[5] = '{32'h0000_F0F0, 32'h0000_0FF0, 4'd4, 32'd0, 1'b1, 1'b1};
      av[6] = '{32'd1, 32'd31, 4'd5, 32'd0, 1'b1, 1'b0};
      av[7] = '{32'h0000_F0F0, 32'h0000_0FF0, 4'd2, 32'd0, 1'b1, 1'b1};
`endif
      rv[0] = '{0, 8'd200, 3};
      rv[1] = '{0, 8'd64, 1};
      rv[2] = '{0, 8'd0, 0};
      rv[3] = '{1, 8'd0, 1};

      for (int i = 0; i < 9; i++) begin
         alu_a = av[i].a;
         alu_b = av[i].b;
         alu_op = av[i].op;
         #1;
         chk($sformatf("alu%0d_res", i), alu_res, av[i].res);
         chk($sformatf("alu%0d_zero", i), 32'(alu_z), 32'(av[i].z));
         chk($sformatf("alu%0d_gt", i), 32'(alu_g), 32'(av[i].g));
      end
      for (int i = 0; i < 20; i++) begin
         ea = $urandom;
         eb = (i % 4 == 0) ? ea : $urandom;
         alu_a = ea;
         alu_b = eb;
         alu_op = 4'(i % 2);
         #1;
         if (i % 2 == 0) chk("alu_rand_add", alu_res, ea + eb);
         else chk("alu_rand_sub", alu_res, ea - eb);
         chk("alu_rand_zero", 32'(alu_z), 32'(alu_res == 0));
         chk("alu_rand_gt", 32'(alu_g), 32'(ea > eb));
      end

      for (int i = 0; i < 4; i++) begin
         run_class(rv[i].mode, rv[i].val, rv[i].cls, $sformatf("run%0d", i));
         if (i == 0) begin
            chk("prog_pc", 32'(pdut.pc_q), 32'd3);
            chk("prog_r1", pdut.regs_q[1], 32'd3);
            chk("prog_r2", pdut.regs_q[2], 32'd3);
            chk("prog_running", 32'(pdut.running_q), 32'd0);
         end
      end

      // Reset in the middle of an accumulation.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      pixel_valid = 1'b1;
      pixel_in = 8'd200;
      repeat (7) @(posedge clk);
      #1;
      chk("mid_busy_start", 32'(dut.start_q), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_class", 32'(class_out), 32'd0);
      chk("mid_done", 32'(done), 32'd0);
      chk("mid_pc", 32'(dut.pc_q), 32'd0);
      chk("mid_start", 32'(dut.start_q), 32'd0);
      chk("mid_running", 32'(dut.running_q), 32'd1);
      chk("mid_ready", 32'(dut.ready_q), 32'd1);
      run_class(0, 8'd130, 2, "after_rst");

      for (int i = 0; i < 3; i++)
         run_class(2, 8'd0, -1, $sformatf("rand%0d", i));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
